fifo_stream_rd: RTL and testbench

Read-side adapter placed directly downstream of the single-clock FIFO (ren/rvalid/empty interface, 1-cycle read latency).
- Converts the FIFO's request/response read protocol into a valid/ready stream with full 1 word/cycle throughput.
- Marks burst boundaries with m_last for the downstream transmit stage (FT245 write path / packet sender).
- Holds a 2-entry output buffer so that backpressure on m_ready never loses a word already requested from the FIFO.

---
 rtl/proto245_pkg.sv | 17 +
 rtl/fifo_stream_rd_chk.sv | 20 ++
 rtl/stream_skid2.sv | 72 +++++++
 rtl/fifo_stream_rd.sv | 102 ++++++++++
 tb/tb_fifo_stream_rd.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/proto245_pkg.sv
// Shared types and constants for the proto245 streaming path.
package proto245_pkg;

  localparam int unsigned STREAM_DATA_W = 8;
  localparam int unsigned BURST_LEN_DEF = 64;

  typedef struct packed {
    logic                     last;
    logic [STREAM_DATA_W-1:0] data;
  } stream_word_t;

  // True when word index idx (0-based) closes a burst of len words.
  function automatic logic burst_wrap_f(input int unsigned idx, input int unsigned len);
    return (idx == (len - 32'd1));
  endfunction

endpackage

// File: rtl/fifo_stream_rd_chk.sv
// Simulation checks on the read adapter's credit accounting.
module fifo_stream_rd_chk (
  input logic       clk,
  input logic       rst,
  input logic       push_i,
  input logic       pop_i,
  input logic [1:0] count_i,
  input logic       inflight_i
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && (count_i == 2'd2) && !pop_i))
        else $error("fifo_stream_rd: read response arrived with the buffer full");
      assert (({1'b0, count_i} + {2'b00, inflight_i}) <= 3'd2)
        else $error("fifo_stream_rd: buffered plus in-flight words exceed 2");
    end
  end

endmodule

// File: rtl/stream_skid2.sv
// Generic 2-entry valid/ready register buffer with a push port; output is the head slot.
module stream_skid2 #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_s;

  assign pop_s = pop_i & (count_q != 2'd0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = push_data_i;
          count_d = 2'd2;
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push/pop: the new word replaces the head or queues behind the tail.
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_rd.sv
// FIFO read-side adapter: request/response reads -> valid/ready stream with burst markers.
module fifo_stream_rd
  import proto245_pkg::*;
#(
  parameter  int unsigned DATA_W    = STREAM_DATA_W,
  parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rvalid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CNT_W-1:0]  burst_cnt
);

  logic             pop_s, push_s, last_s;
  logic [1:0]       count_s;
  logic [2:0]       occ_s;
  logic [DATA_W:0]  head_s;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] push_idx_q, push_idx_d;

  assign pop_s    = m_valid & m_ready;
  // A response is only trusted if we asked for it; this drops a stale one after reset.
  assign push_s   = fifo_rvalid & inflight_q;
  assign occ_s    = {1'b0, count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign fifo_ren = ~rst & ~fifo_empty & (occ_s < 3'd2);

  // Words leave in push order, so tagging the burst position at push time
  // equals evaluating burst_cnt when the word reaches the head.
  assign last_s = burst_wrap_f(32'(push_idx_q), BURST_LEN);

  always_comb begin
    inflight_d  = fifo_ren;
    push_idx_d  = push_idx_q;
    burst_cnt_d = burst_cnt_q;
    if (push_s) begin
      if (last_s) begin
        push_idx_d = '0;
      end else begin
        push_idx_d = push_idx_q + CNT_W'(1);
      end
    end else begin
      push_idx_d = push_idx_q;
    end
    if (pop_s) begin
      if (m_last) begin
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      push_idx_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      push_idx_q  <= push_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  stream_skid2 #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i ({last_s, fifo_rdata}),
    .pop_i       (m_ready),
    .head_o      (head_s),
    .valid_o     (m_valid),
    .count_o     (count_s)
  );

  fifo_stream_rd_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .count_i    (count_s),
    .inflight_i (inflight_q)
  );

  assign m_data    = head_s[DATA_W-1:0];
  assign m_last    = head_s[DATA_W];
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: queue-based FIFO and stream model, directed steps with random backpressure.
module tb_fifo_stream_rd;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = $clog2(BL + 1);

  logic          clk = 1'b0;
  logic          rst, fifo_empty, fifo_ren, fifo_rvalid;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] fifo_rdata, m_data;
  logic [CW-1:0] burst_cnt;

  always #5 clk = ~clk;

  fifo_stream_rd #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .fifo_rvalid (fifo_rvalid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .burst_cnt   (burst_cnt)
  );

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] fq[$];          // FIFO contents
  logic [DW-1:0] sb[$];          // words requested but not yet delivered, in order
  logic [DW-1:0] last_words[$];  // words delivered with m_last
  int            pcnt;           // words delivered since reset
  bit            infl_m;         // a requested word is still on its way
  bit            prev_hold;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  int            cyc, ren_pulses, pops, first_ren, first_v, first_pop, last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    ren_pulses = 0; pops = 0; first_ren = -1; first_v = -1; first_pop = -1; last_pop = -1;
    last_words.delete();
  endtask

  // One clock cycle: drive, sample at the falling edge, then advance the model across the rising edge.
  task automatic tick(input bit rdy, input bit rs, input bit stale);
    bit            ren, v, l, pop, exp_ren;
    logic [DW-1:0] d, w;
    logic [CW-1:0] bc;
    m_ready    = rdy;
    rst        = rs;
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
    ren = fifo_ren; v = m_valid; d = m_data; l = m_last; bc = burst_cnt;
    pop = v & rdy;
    if (rs) begin
      chk("ren_in_rst", ren, 0);
    end else begin
      exp_ren = (fq.size() > 0) && ((sb.size() - int'(pop)) < 2);
      chk("fifo_ren", ren, exp_ren);
      chk("m_valid", v, (sb.size() - int'(infl_m)) > 0);
      chk("burst_cnt", bc, pcnt % BL);
      if (prev_hold) begin
        chk("hold_data", d, prev_d);
        chk("hold_last", l, prev_l);
      end
      if (pop && sb.size() > 0) begin
        chk("m_data", d, sb[0]);
        chk("m_last", l, (pcnt % BL) == (BL - 1));
        void'(sb.pop_front());
        pcnt++; pops++;
        if (l) last_words.push_back(d);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (ren && first_ren < 0) first_ren = cyc;
      if (v && first_v < 0) first_v = cyc;
      prev_hold = v & ~rdy; prev_d = d; prev_l = l;
    end
    @(posedge clk); #1;
    if (ren && !rs && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_rdata  = w;
      fifo_rvalid = 1'b1;
      sb.push_back(w);
      ren_pulses++;
    end else begin
      fifo_rvalid = 1'b0;
    end
    if (rs) begin
      sb.delete(); fq.delete(); pcnt = 0; infl_m = 0; prev_hold = 0;
    end else begin
      infl_m = ren;
    end
    if (stale) begin
      fifo_rvalid = 1'b1;
      fifo_rdata  = 8'hEE;
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic do_reset(input bit stale);
    tick(1'b0, 1'b1, stale);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", burst_cnt, 0);
  endtask

  task automatic drain(input bit rand_rdy);
    for (int k = 0; k < 200 && (fq.size() + sb.size()) > 0; k++)
      tick(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
    chk("drain_done", fq.size() + sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0; fifo_rvalid = 1'b0; fifo_rdata = 8'h00; fifo_empty = 1'b1;
    pcnt = 0; infl_m = 0; prev_hold = 0; cyc = 0;
    clear_stats();
    do_reset(1'b0);
    do_reset(1'b0);

    // Full-rate stream of 10 words, bursts of 4.
    for (int i = 0; i < 10; i++) fq.push_back(8'(i));
    repeat (14) tick(1'b1, 1'b0, 1'b0);
    chk("latency", first_v - first_ren, 2);
    chk("t1_pops", pops, 10);
    chk("t1_no_gap", last_pop - first_pop + 1, 10);
    chk("t1_valid_end", m_valid, 0);
    chk("t1_cnt_end", burst_cnt, 2);
    chk("t1_nlast", last_words.size(), 2);
    if (last_words.size() == 2) begin
      chk("t1_last0", last_words[0], 8'h03);
      chk("t1_last1", last_words[1], 8'h07);
    end

    // Random backpressure on 8 words.
    do_reset(1'b0);
    clear_stats();
    for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
    drain(1'b1);
    chk("t2_pops", pops, 8);

    // Consumer stalled for 20 cycles with 16 words waiting.
    do_reset(1'b0);
    clear_stats();
    for (int i = 0; i < 16; i++) fq.push_back(8'h40 + 8'(i));
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    chk("t3_ren_pulses", ren_pulses, 2);
    chk("t3_fifo_level", fq.size(), 14);
    chk("t3_valid", m_valid, 1);
    chk("t3_data", m_data, 8'h40);
    drain(1'b0);
    chk("t3_pops", pops, 16);

    // FIFO runs dry mid-burst, then refills with the burst's last word.
    do_reset(1'b0);
    clear_stats();
    for (int i = 0; i < 3; i++) fq.push_back(8'(i));
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    chk("t4_gap_valid", m_valid, 0);
    chk("t4_gap_cnt", burst_cnt, 3);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    fq.push_back(8'h03);
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    chk("t4_nlast", last_words.size(), 1);
    if (last_words.size() == 1) chk("t4_last", last_words[0], 8'h03);
    chk("t4_cnt_wrap", burst_cnt, 0);

    // Reset while streaming with a word in flight, plus a stale response after reset.
    do_reset(1'b0);
    clear_stats();
    for (int i = 0; i < 10; i++) fq.push_back(8'h60 + 8'(i));
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    clear_stats();
    for (int i = 0; i < 5; i++) fq.push_back(8'h80 + 8'(i));
    drain(1'b1);
    chk("t5_pops", pops, 5);
    chk("t5_cnt_end", burst_cnt, 1);
    if (last_words.size() > 0) chk("t5_last", last_words[0], 8'h83);
    else chk("t5_nlast", last_words.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
